seq_mag_comparator: RTL

Multi-cycle, parametrised magnitude comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and reports less-than, greater-than and equal flags. It supports unsigned and two's-complement modes and can stop early at the first differing digit. It is the sequential, width-scalable successor to the team's 4-bit combinational comparator, intended for datapaths where a single-cycle WIDTH-bit compare cannot meet timing.

---
 rtl/seq_mag_comparator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - multi-cycle MSB-first magnitude comparator, DIGIT bits per clock
module seq_mag_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             signed_mode,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    output logic                             busy,
    output logic                             done,
    output logic                             a_lt_b,
    output logic                             a_gt_b,
    output logic                             a_eq_b,
    output logic [$clog2(WIDTH/DIGIT):0]     cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    LAST_IDX = CW'(NDIG - 1);

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ra_q, ra_d;
    logic [WIDTH-1:0]  rb_q, rb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              decided_q, decided_d;
    logic              dec_lt_q, dec_lt_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic [CW-1:0]     cycles_q, cycles_d;
    logic              done_q, done_d;

    logic [DIGIT-1:0]  digit_a;
    logic [DIGIT-1:0]  digit_b;
    logic              differ;
    logic              digit_lt;
    logic              last_digit;
    logic              res_decided;
    logic              res_lt;
    logic              finish;

    assign digit_a    = ra_q[WIDTH-1 -: DIGIT];
    assign digit_b    = rb_q[WIDTH-1 -: DIGIT];
    assign differ     = (digit_a != digit_b);
    assign digit_lt   = (digit_a < digit_b);
    assign last_digit = (cnt_q == LAST_IDX);

    // A decision made on an earlier digit always wins over the current one.
    assign res_decided = decided_q || differ;
    assign res_lt      = decided_q ? dec_lt_q : digit_lt;
    assign finish      = ((EARLY_EXIT != 0) && differ) || last_digit;

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        dec_lt_d  = dec_lt_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        cycles_d  = cycles_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto offset binary,
                    // so the per-digit unsigned compare stays correct.
                    ra_d      = signed_mode ? (a ^ MSB_MASK) : a;
                    rb_d      = signed_mode ? (b ^ MSB_MASK) : b;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    dec_lt_d  = 1'b0;
                    state_d   = CMP;
                end
            end
            CMP: begin
                ra_d  = ra_q << DIGIT;
                rb_d  = rb_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (!decided_q && differ) begin
                    decided_d = 1'b1;
                    dec_lt_d  = digit_lt;
                end
                if (finish) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    lt_d     = res_decided && res_lt;
                    gt_d     = res_decided && !res_lt;
                    eq_d     = !res_decided;
                    cycles_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            dec_lt_q  <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            dec_lt_q  <= dec_lt_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            cycles_q  <= cycles_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q == CMP);
    assign done   = done_q;
    assign a_lt_b = lt_q;
    assign a_gt_b = gt_q;
    assign a_eq_b = eq_q;
    assign cycles = cycles_q;

endmodule
